dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests.
//  Accepts one word access at a time and completes it after a fixed LATENCY.
//  Holds stall_o high until completion; hazard logic uses it to freeze PC/IFID/IDEX/EXMEM.
//  Sits where the MEM stage reaches data memory, driven by EXMEM ALU result/wrdata/MemRead/MemWrite.
// PARAMETERS
//  DEPTH_WORDS  256  storage depth in 32-bit words; power of two
//  LATENCY      4    cycles from accept to done_o; legal range 1..15
// PORTS
//  clk_i    in   1   clock
//  rst_i    in   1   reset, asynchronous, active-high
//  req_i    in   1   access request (EXMEM MemRead|MemWrite); held high by CPU while stalled
//  we_i     in   1   1 = store, 0 = load; sampled at accept
//  addr_i   in   32  byte address (EXMEM ALU result); sampled at accept
//  wdata_i  in   32  store data (EXMEM wrdata); sampled at accept
//  stall_o  out  1   pipeline hold request
//  done_o   out  1   one-cycle completion pulse
//  rdata_o  out  32  load data; valid with done_o, held until next completion
//  err_o    out  1   pulses with done_o when the access is misaligned or out of range
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, counter=0, stall_o=0, done_o=0, err_o=0, rdata_o=0.
//    Latched request discarded; a pending store is never written. Storage array not cleared.
//  - FSM states: IDLE, BUSY, DONE.
//    IDLE: req_i=1 accepts (cycle T): latch we/addr/wdata; LATENCY=1 -> DONE, else BUSY with cnt=LATENCY-1.
//    BUSY: cnt decrements each cycle; cnt==1 -> DONE. req_i/addr_i/we_i/wdata_i ignored.
//    DONE: done_o=1 for exactly one cycle (T+LATENCY); always -> IDLE; no accept in DONE.
//  - stall_o = (IDLE & req_i) | BUSY, combinational. High for cycles T..T+LATENCY-1, low in DONE.
//    This lets the held instruction leave MEM at the end of the DONE cycle.
//  - Store: array[addr[2+:log2(DEPTH)]] written on the clock edge entering DONE; rdata_o unchanged.
//  - Load: rdata_o <= array word on the edge entering DONE. Holds through later stores/errors until the next load.
//  - Error: addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS. Full LATENCY is still taken, nothing is written,
//    rdata_o=0 for a load, err_o=1 coincident with done_o.
//  - Back-to-back: the next accept is earliest at T+LATENCY+1, so throughput is 1 access per LATENCY+1 cycles.
//  - req_i dropping mid-BUSY: the transaction still completes (the CPU contract is violated but the result is defined).
//  - Read after write to the same word returns the new data; there is no bypass hazard because accesses are serialized.
// STRUCTURE
//  - dmem_pkg: state enum (IDLE/BUSY/DONE), word width 32, cnt width 4.
//  - One sub-module, dmem_array: DEPTH_WORDS x 32 synchronous-write/synchronous-read array,
//    with ports we, waddr/raddr, wdata, rdata. No reset.
//  - Top level: FSM, latency counter, request latch, range/alignment check, output registers.
// TESTING
//  - Reset: assert rst_i mid-BUSY of a store to 0x10 -> stall_o=0 immediately; after release, load 0x10 returns the preloaded value.
//  - Store then load, LATENCY=4: store 0xDEADBEEF @0x20 at T=0 -> stall_o high at T0..3, done_o at T4;
//    load @0x20 at T5 -> done_o at T9, rdata_o=0xDEADBEEF.
//  - LATENCY=1: load @0x04 with 0x12345678 preloaded -> stall_o high only in the accept cycle,
//    done_o next cycle, rdata_o=0x12345678.
//  - Misaligned store to 0x22 -> err_o and done_o at T+LATENCY; word 0x20 unchanged; rdata_o keeps its prior value.
//  - Out of range, DEPTH=256: load 0x400 -> err_o=1, rdata_o=0, latency unchanged.
//  - Inputs change during BUSY: alter addr_i/wdata_i and drop req_i -> the original latched request completes exactly once;
//    no accept in DONE even with req_i high.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // A word access is illegal when it is not word aligned or lands past the array.
    function automatic logic is_bad_addr(input word_t addr, input int unsigned depth);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with synchronous write and synchronous read; contents survive reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    input  word_t                          wdata,
    output word_t                          rdata
);

    word_t mem [DEPTH_WORDS];

    // Write port and registered read port share the clock; read returns pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one word access, completes it LATENCY
// cycles later with a done pulse, and holds stall_o while the access is outstanding.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned    IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    word_t            lat_addr;
    word_t            lat_wdata;
    word_t            rdata_hold;

    logic             accept;
    logic             finish;
    logic             cur_we;
    logic             cur_err;
    word_t            cur_addr;
    word_t            cur_wdata;
    logic [IDX_W-1:0] cur_idx;
    logic             arr_we;
    word_t            arr_rdata;

    // Request view: live inputs while idle (so LATENCY=1 can finish on the accept edge), latch otherwise.
    always_comb begin
        accept    = (state == IDLE) && req_i;
        finish    = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == CNT_ONE));
        cur_we    = (state == IDLE) ? we_i    : lat_we;
        cur_addr  = (state == IDLE) ? addr_i  : lat_addr;
        cur_wdata = (state == IDLE) ? wdata_i : lat_wdata;
        cur_err   = is_bad_addr(cur_addr, DEPTH_WORDS);
        cur_idx   = cur_addr[2 +: IDX_W];
        arr_we    = finish && cur_we && !cur_err;
        stall_o   = accept || (state == BUSY);
    end

    // The array's registered read lands in the DONE cycle, so the load result is
    // steered straight to rdata_o then and captured into rdata_hold for later cycles.
    always_comb begin
        rdata_o = rdata_hold;
        if ((state == DONE) && !lat_we) begin
            rdata_o = err_o ? '0 : arr_rdata;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk_i),
        .we   (arr_we),
        .waddr(cur_idx),
        .raddr(cur_idx),
        .wdata(cur_wdata),
        .rdata(arr_rdata)
    );

    // Control FSM with latency counter, request latch and registered completion flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_hold <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            done_o <= finish;
            err_o  <= finish && cur_err;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        lat_we    <= we_i;
                        lat_addr  <= addr_i;
                        lat_wdata <= wdata_i;
                        cnt       <= CNT_INIT;
                        state     <= (LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    rdata_hold <= rdata_o;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: instance 0 uses LATENCY=4, instance 1 uses LATENCY=1.
module tb_dmem_responder;

    localparam int unsigned LAT0  = 4;
    localparam int unsigned LAT1  = 1;
    localparam int unsigned DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        stall [2];
    logic        done  [2];
    logic [31:0] rdata [2];
    logic        err   [2];

    int checks;
    int failures;

    // Reference model: plain word array per instance plus the last load result.
    logic [31:0] mem_m [2][DEPTH];
    bit          wr_m  [2][DEPTH];
    logic [31:0] rd_m  [2];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_e;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [12];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .stall_o(stall[0]), .done_o(done[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .stall_o(stall[1]), .done_o(done[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model of one completed access; returns the expected error flag and rdata_o.
    task automatic model_apply(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                               output logic e, output logic [31:0] rd);
        int unsigned widx;
        widx = a / 4;
        e = (a % 4 != 0) || (widx >= DEPTH);
        if (w) begin
            if (!e) begin
                mem_m[i][widx] = d;
                wr_m[i][widx]  = 1'b1;
            end
        end else begin
            rd_m[i] = e ? 32'h0 : mem_m[i][widx];
        end
        rd = rd_m[i];
    endtask

    // One complete access with req held until the DONE cycle, checked cycle by cycle.
    task automatic access(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_e, input logic [31:0] exp_rd, input string nm);
        int unsigned lat;
        lat = (i == 0) ? LAT0 : LAT1;
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        #1;
        chk1({nm, "_accept_stall"}, stall[i], 1'b1);
        for (int unsigned k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                chk1($sformatf("%s_busy_stall%0d", nm, k), stall[i], 1'b1);
                chk1($sformatf("%s_busy_done%0d", nm, k), done[i], 1'b0);
            end else begin
                chk1({nm, "_done"}, done[i], 1'b1);
                chk1({nm, "_done_stall"}, stall[i], 1'b0);
                chk1({nm, "_err"}, err[i], exp_e);
                chk32({nm, "_rdata"}, rdata[i], exp_rd);
            end
        end
        req[i] = 1'b0;
        we[i]  = 1'b0;
    endtask

    task automatic model_access(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                                input string nm);
        logic        e;
        logic [31:0] rd;
        model_apply(i, w, a, d, e, rd);
        access(i, w, a, d, e, rd, nm);
    endtask

    initial begin
        logic        e;
        logic [31:0] rd;
        int          dones;

        checks = 0;
        failures = 0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
            rd_m[i] = '0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                mem_m[i][j] = '0;
                wr_m[i][j]  = 1'b0;
            end
        end

        tbl[0]  = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_0022, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0000_0000};
        tbl[5]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_C0DE, 1'b0, 32'h0000_0000};
        tbl[6]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0BAD_C0DE};
        tbl[7]  = '{1'b0, 32'h0000_03FD, 32'h0,         1'b1, 32'h0000_0000};
        tbl[8]  = '{1'b1, 32'h0000_0000, 32'h1357_9BDF, 1'b0, 32'h0000_0000};
        tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1357_9BDF};
        tbl[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};
        tbl[11] = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0BAD_C0DE};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk1($sformatf("reset_stall%0d", i), stall[i], 1'b0);
            chk1($sformatf("reset_done%0d", i), done[i], 1'b0);
            chk1($sformatf("reset_err%0d", i), err[i], 1'b0);
            chk32($sformatf("reset_rdata%0d", i), rdata[i], 32'h0);
        end
        rst = 1'b0;

        // Directed table, back-to-back on the LATENCY=4 instance
        for (int n = 0; n < 12; n++) begin
            model_apply(0, tbl[n].w, tbl[n].a, tbl[n].d, e, rd);
            access(0, tbl[n].w, tbl[n].a, tbl[n].d, tbl[n].exp_e, tbl[n].exp_rd, $sformatf("tbl%0d", n));
        end

        // Reset in the middle of a store: the store must never land
        access(0, 1'b1, 32'h10, 32'hA5A5_0010, 1'b0, 32'h0BAD_C0DE, "rst_pre");
        model_apply(0, 1'b1, 32'h10, 32'hA5A5_0010, e, rd);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h1111_2222;
        @(negedge clk);
        #2;
        chk1("rst_mid_busy_stall", stall[0], 1'b1);
        rst = 1'b1;
        req[0] = 1'b0; we[0] = 1'b0;
        #1;
        chk1("rst_async_stall", stall[0], 1'b0);
        chk1("rst_async_done", done[0], 1'b0);
        chk32("rst_async_rdata", rdata[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd_m[0] = '0;
        rd_m[1] = '0;
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA5A5_0010, "rst_post_load");
        model_apply(0, 1'b0, 32'h10, 32'h0, e, rd);

        // Inputs disturbed mid-BUSY; req held in DONE must not start a new access
        model_access(0, 1'b1, 32'h34, 32'h3434_3434, "pert_pre");
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h3030_3030;
        #1;
        chk1("pert_accept_stall", stall[0], 1'b1);
        dones = 0;
        for (int unsigned k = 1; k <= LAT0 + 3; k++) begin
            @(negedge clk);
            if (done[0] === 1'b1) dones++;
            if (k == 1) begin
                chk1("pert_busy_stall_req_low", stall[0], 1'b1);
                req[0] = 1'b0; we[0] = 1'b0; addr[0] = 32'h34; wdata[0] = 32'hFFFF_FFFF;
            end
            if (k == LAT0) begin
                chk1("pert_done_at_latency", done[0], 1'b1);
                chk1("pert_done_err", err[0], 1'b0);
                req[0] = 1'b1;
            end
            if (k == LAT0 + 1) begin
                req[0] = 1'b0;
                #1;
                chk1("pert_no_accept_in_done", stall[0], 1'b0);
            end
        end
        chk32("pert_done_count", 32'(dones), 32'd1);
        model_apply(0, 1'b1, 32'h30, 32'h3030_3030, e, rd);
        model_access(0, 1'b0, 32'h30, 32'h0, "pert_load30");
        model_access(0, 1'b0, 32'h34, 32'h0, "pert_load34");

        // LATENCY=1 instance
        access(1, 1'b1, 32'h04, 32'h1234_5678, 1'b0, 32'h0, "lat1_store");
        model_apply(1, 1'b1, 32'h04, 32'h1234_5678, e, rd);
        access(1, 1'b0, 32'h04, 32'h0, 1'b0, 32'h1234_5678, "lat1_load");
        model_apply(1, 1'b0, 32'h04, 32'h0, e, rd);

        // Randomized accesses against the model
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                logic        w;
                logic [31:0] a;
                int unsigned sel;
                sel = $urandom_range(0, 9);
                w   = 1'($urandom_range(0, 1));
                if (sel == 0) begin
                    a = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
                end else if (sel == 1) begin
                    a = $urandom_range(DEPTH, 32'h3FFF_FFFF) * 4;
                end else begin
                    a = $urandom_range(0, 15) * 4;
                    if (!wr_m[i][a / 4]) w = 1'b1;
                end
                model_access(i, w, a, $urandom, $sformatf("rnd%0d_%0d", n, i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
